// File: rtl/ptcalc_pt_pkg.sv
// Shared defaults, a constant clog2 helper and the accumulator FSM state type
// for the ptcalc pT accumulate/round/saturate stage.
package ptcalc_pt_pkg;

  localparam int unsigned PROD_W_DEF    = 33;
  localparam int unsigned MAX_TERMS_DEF = 8;
  localparam int unsigned SHIFT_DEF     = 8;
  localparam int unsigned PT_W_DEF      = 16;

  // Ceiling log2; usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {ACC, RND, OUT} state_t;

endpackage

// File: rtl/ptcalc_round_clamp.sv
// Combinational round-half-up, arithmetic rescale by SHIFT, and clamp of a
// signed accumulator to an unsigned PT_W word with a saturation flag.
module ptcalc_round_clamp #(
  parameter int unsigned ACC_W = 36,
  parameter int unsigned SHIFT = 8,
  parameter int unsigned PT_W  = 16
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [PT_W-1:0]  pt_o,
  output logic                    sat_o
);

  // One extra bit so adding the rounding constant can never wrap.
  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT - 1);

  logic signed [ACC_W:0] sum_s;
  logic signed [ACC_W:0] r_s;

  // Round, shift, then clamp: negative -> 0, too large -> all ones.
  always_comb begin
    sum_s = {acc_i[ACC_W-1], acc_i} + HALF;
    r_s   = sum_s >>> SHIFT;
    pt_o  = r_s[PT_W-1:0];
    sat_o = 1'b0;
    if (r_s[ACC_W]) begin
      pt_o  = '0;
      sat_o = 1'b1;
    end else if (|r_s[ACC_W-1:PT_W]) begin
      pt_o  = '1;
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/ptcalc_pt_accum_sat.sv
// pT accumulate/round/saturate stage: sums signed products of one evaluation,
// rounds and clamps on the last term, and offers the result on valid/ready.
// Optional saturation event counter enabled by PTCALC_PT_SAT_CNT_EN.
module ptcalc_pt_accum_sat
  import ptcalc_pt_pkg::*;
#(
  parameter int unsigned PROD_W    = PROD_W_DEF,
  parameter int unsigned MAX_TERMS = MAX_TERMS_DEF,
  parameter int unsigned SHIFT     = SHIFT_DEF,
  parameter int unsigned PT_W      = PT_W_DEF
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [PROD_W-1:0] prod_din,
  input  logic              prod_vld,
  input  logic              prod_last,
  output logic              prod_rdy,
  output logic [PT_W-1:0]   pt_dout,
  output logic              pt_sat,
  output logic              pt_err,
  output logic              pt_vld,
  input  logic              pt_rdy
`ifdef PTCALC_PT_SAT_CNT_EN
  ,
  output logic [15:0]       sat_cnt
`endif
);

  localparam int unsigned CNT_W = clog2(MAX_TERMS);
  localparam int unsigned ACC_W = PROD_W + CNT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_TERMS - 1);

  state_t state_q, state_d;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] prod_ext;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [PT_W-1:0]         dout_q, dout_d;
  logic                    sat_q, sat_d;
  logic                    perr_q, perr_d;
  logic                    accept, hshake, term_end;
  logic [PT_W-1:0]         rc_pt;
  logic                    rc_sat;

  assign prod_ext = {{CNT_W{prod_din[PROD_W-1]}}, prod_din};

  ptcalc_round_clamp #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .PT_W  (PT_W)
  ) u_round_clamp (
    .acc_i (acc_q),
    .pt_o  (rc_pt),
    .sat_o (rc_sat)
  );

  // State register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state_q <= ACC;
    else        state_q <= state_d;
  end

  // Next state: ACC until the closing term, one RND cycle, OUT until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (accept && term_end) state_d = RND;
      RND:     state_d = OUT;
      OUT:     if (pt_rdy) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // Handshake outputs decoded from state only.
  always_comb begin
    prod_rdy = (state_q == ACC) && !ap_rst;
    pt_vld   = (state_q == OUT);
    accept   = prod_vld && prod_rdy;
    hshake   = pt_vld && pt_rdy;
    term_end = prod_last || (cnt_q == LAST_CNT);
  end

  // Datapath next values: accumulate, capture rounded result, clear on handoff.
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    dout_d = dout_q;
    sat_d  = sat_q;
    perr_d = perr_q;
    if (accept) begin
      acc_d = acc_q + prod_ext;
      cnt_d = cnt_q + CNT_W'(1);
      if (!prod_last && (cnt_q == LAST_CNT)) err_d = 1'b1;
    end
    if (state_q == RND) begin
      dout_d = rc_pt;
      sat_d  = rc_sat;
      perr_d = err_q;
    end
    if (hshake) begin
      acc_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      dout_q <= '0;
      sat_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      dout_q <= dout_d;
      sat_q  <= sat_d;
      perr_q <= perr_d;
    end
  end

  assign pt_dout = dout_q;
  assign pt_sat  = sat_q;
  assign pt_err  = perr_q;

`ifdef PTCALC_PT_SAT_CNT_EN
  logic [15:0] sat_cnt_q;

  // Count clamped results, sticking at the maximum.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      sat_cnt_q <= '0;
    end else if ((state_q == RND) && rc_sat && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_ptcalc_pt_accum_sat.sv
// Directed bench for ptcalc_pt_accum_sat with default parameters.
module tb_ptcalc_pt_accum_sat;

  logic        ap_clk;
  logic        ap_rst;
  logic [32:0] prod_din;
  logic        prod_vld;
  logic        prod_last;
  logic        prod_rdy;
  logic [15:0] pt_dout;
  logic        pt_sat;
  logic        pt_err;
  logic        pt_vld;
  logic        pt_rdy;
`ifdef PTCALC_PT_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  ptcalc_pt_accum_sat dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .prod_din  (prod_din),
    .prod_vld  (prod_vld),
    .prod_last (prod_last),
    .prod_rdy  (prod_rdy),
    .pt_dout   (pt_dout),
    .pt_sat    (pt_sat),
    .pt_err    (pt_err),
    .pt_vld    (pt_vld),
    .pt_rdy    (pt_rdy)
`ifdef PTCALC_PT_SAT_CNT_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic send_term(input int v, input bit last);
    prod_din  = {v[31], v};
    prod_vld  = 1'b1;
    prod_last = last;
    for (int i = 0; i < 20 && !prod_rdy; i++) tick();
    chk("prod_rdy_wait", 32'(prod_rdy), 32'd1);
    tick();
    prod_vld  = 1'b0;
    prod_last = 1'b0;
    prod_din  = '0;
  endtask

  task automatic get_result(input string tag, input int dout, input bit sat, input bit err);
    for (int i = 0; i < 20 && !pt_vld; i++) tick();
    chk({tag, "_vld"},  32'(pt_vld),  32'd1);
    chk({tag, "_dout"}, 32'(pt_dout), 32'(dout));
    chk({tag, "_sat"},  32'(pt_sat),  32'(sat));
    chk({tag, "_err"},  32'(pt_err),  32'(err));
    pt_rdy = 1'b1;
    tick();
    pt_rdy = 1'b0;
    chk({tag, "_vld_drop"}, 32'(pt_vld), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ap_rst    = 1'b1;
    prod_vld  = 1'b0;
    prod_last = 1'b0;
    prod_din  = '0;
    pt_rdy    = 1'b0;
    tick();
    tick();
    chk("rst_prod_rdy", 32'(prod_rdy), 32'd0);
    chk("rst_pt_vld",   32'(pt_vld),   32'd0);
    chk("rst_pt_dout",  32'(pt_dout),  32'd0);
    chk("rst_pt_sat",   32'(pt_sat),   32'd0);
    chk("rst_pt_err",   32'(pt_err),   32'd0);
`ifdef PTCALC_PT_SAT_CNT_EN
    chk("rst_sat_cnt",  32'(sat_cnt),  32'd0);
`endif
    ap_rst = 1'b0;
    #1;
    chk("idle_prod_rdy", 32'(prod_rdy), 32'd1);

    // Single term 25600 with exact latency: accept, RND, OUT, handshake.
    pt_rdy    = 1'b1;
    prod_din  = 33'd25600;
    prod_vld  = 1'b1;
    prod_last = 1'b1;
    tick();
    prod_vld  = 1'b0;
    prod_last = 1'b0;
    chk("lat_rnd_vld", 32'(pt_vld),   32'd0);
    chk("lat_rnd_rdy", 32'(prod_rdy), 32'd0);
    tick();
    chk("lat_out_vld",  32'(pt_vld),  32'd1);
    chk("lat_out_dout", 32'(pt_dout), 32'd100);
    chk("lat_out_sat",  32'(pt_sat),  32'd0);
    chk("lat_out_err",  32'(pt_err),  32'd0);
    tick();
    chk("lat_done_vld", 32'(pt_vld),   32'd0);
    chk("lat_done_rdy", 32'(prod_rdy), 32'd1);
    pt_rdy = 1'b0;

    // Rounding.
    send_term(128, 1'b1);
    get_result("rnd128", 1, 1'b0, 1'b0);
    send_term(127, 1'b1);
    get_result("rnd127", 0, 1'b0, 1'b0);
    send_term(384, 1'b0);
    send_term(-128, 1'b1);
    get_result("rnd256", 1, 1'b0, 1'b0);
    send_term(-100, 1'b0);
    send_term(-28, 1'b1);
    get_result("rndm128", 0, 1'b0, 1'b0);

    // Clamping low and high.
    send_term(-512, 1'b1);
    get_result("clamp_lo", 0, 1'b1, 1'b0);
`ifdef PTCALC_PT_SAT_CNT_EN
    chk("sat_cnt_1", 32'(sat_cnt), 32'd1);
`endif
    send_term(16777216, 1'b0);
    send_term(256, 1'b1);
    get_result("clamp_hi", 65535, 1'b1, 1'b0);
`ifdef PTCALC_PT_SAT_CNT_EN
    chk("sat_cnt_2", 32'(sat_cnt), 32'd2);
`endif

    // Backpressure with a product waiting upstream.
    send_term(256, 1'b1);
    for (int i = 0; i < 20 && !pt_vld; i++) tick();
    prod_din  = 33'd1234;
    prod_vld  = 1'b1;
    prod_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_prod_rdy", 32'(prod_rdy), 32'd0);
      chk("bp_pt_vld",   32'(pt_vld),   32'd1);
      chk("bp_pt_dout",  32'(pt_dout),  32'd1);
    end
    prod_vld  = 1'b0;
    prod_last = 1'b0;
    get_result("bp", 1, 1'b0, 1'b0);
    send_term(256, 1'b1);
    get_result("bp_next", 1, 1'b0, 1'b0);

    // Term overflow: 8 terms with no last.
    for (int i = 0; i < 8; i++) send_term(256, 1'b0);
    chk("ovf_prod_rdy", 32'(prod_rdy), 32'd0);
    get_result("ovf", 8, 1'b0, 1'b1);
    send_term(256, 1'b1);
    get_result("post_ovf", 1, 1'b0, 1'b0);

    // Asynchronous reset mid-evaluation discards the partial sum.
    send_term(256, 1'b0);
    send_term(256, 1'b0);
    send_term(256, 1'b0);
    ap_rst = 1'b1;
    #1;
    chk("mrst_prod_rdy", 32'(prod_rdy), 32'd0);
    chk("mrst_pt_vld",   32'(pt_vld),   32'd0);
    chk("mrst_pt_dout",  32'(pt_dout),  32'd0);
    chk("mrst_pt_sat",   32'(pt_sat),   32'd0);
    chk("mrst_pt_err",   32'(pt_err),   32'd0);
`ifdef PTCALC_PT_SAT_CNT_EN
    chk("mrst_sat_cnt",  32'(sat_cnt),  32'd0);
`endif
    tick();
    ap_rst = 1'b0;
    #1;
    send_term(512, 1'b1);
    get_result("post_rst", 2, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
